cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Round-robin arbiter that shares the single common data bus (CDB) between the execute stages (ALU, multiplier, load unit).
- Each execute stage presents valid/tag/value/flags and holds them until it sees its canGo bit. The arbiter drives canGo to exactly one stage per cycle and registers the winner onto the CDB for the ROB and reservation stations.
- Sits between the execute stages and the ROB/RS broadcast network.

Parameters:
- NUM_UNITS, 3, number of requesting execute stages (2..8).
- ROBsize, 16, ROB entries.
- ROBsizeLog, $clog2(ROBsize+1), tag width (5 at default).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- valid_i  in  NUM_UNITS  per-unit result-ready request (execute stage valid_o).
- tag_i  in  NUM_UNITS*ROBsizeLog  per-unit ROB tag; unit k occupies bits [k*ROBsizeLog +: ROBsizeLog].
- val_i  in  NUM_UNITS*64  per-unit result value; unit k at [k*64 +: 64].
- flags_i  in  NUM_UNITS*4  per-unit {carry,overflow,zero,negative}; unit k at [k*4 +: 4].
- cdbStall_i  in  1  ROB cannot accept a broadcast this cycle.
- flush_i  in  1  mispredict flush.
- canGo_o  out  NUM_UNITS  one-hot grant; drives execute stage canGo_i.
- cdbValid_o  out  1  CDB broadcast valid.
- cdbTag_o  out  ROBsizeLog  broadcast tag.
- cdbVal_o  out  64  broadcast value.
- cdbFlags_o  out  4  broadcast flags.
- cdbUnit_o  out  $clog2(NUM_UNITS)  index of the unit that produced the broadcast.

Behaviour:
- Reset, synchronous, active-high:
  - rrPtr_r=0, cdbValid_o=0, cdbTag_o=0, cdbVal_o=0, cdbFlags_o=0, cdbUnit_o=0.
  - canGo_o=0 while reset_i is high.
- Grant (combinational, same cycle):
  - If cdbStall_i or flush_i is high, canGo_o=0.
  - Otherwise, scan units rrPtr_r, rrPtr_r+1, ... with wrap modulo NUM_UNITS; the first unit with valid_i set gets its canGo_o bit.
  - canGo_o is one-hot or zero. A canGo bit is never asserted to a unit whose valid_i is low.
- Pointer update:
  - On a grant to unit k: rrPtr_r <= (k+1) mod NUM_UNITS. Wrap is explicit for non-power-of-2 NUM_UNITS; the pointer must never hold a value >= NUM_UNITS.
  - With no grant, rrPtr_r holds.
- CDB register, 1-cycle latency:
  - At the edge where canGo_o[k]=1: cdbValid_o<=1 and tag/val/flags are taken from unit k; cdbUnit_o<=k.
  - With no grant: cdbValid_o<=0. Data outputs hold their last value and are don't-care when valid is 0.
- Handshake:
  - The execute stage retires its result on the edge where canGo is high. Its data is stable during the grant cycle.
  - An ungranted requester keeps valid_i high and is re-arbitrated every cycle.
- Fairness:
  - With all N units requesting continuously, each unit is granted exactly once per N cycles.
  - A single requester is granted every cycle (back-to-back).
- Flush:
  - flush_i high: no grant that cycle, and cdbValid_o<=0 at the next edge. A broadcast registered in the flush cycle is dropped.
  - rrPtr_r is unchanged.
- cdbStall_i high: no grant, and cdbValid_o<=0 at the next edge. Requests wait; no data is lost.
- Simultaneous flush_i and cdbStall_i: same as flush.
- Reset mid-operation: pending grants are abandoned; outputs take their reset values at the next edge.

Optional Feature:
- Macro: CDB_ARB_PERF_EN.
- When defined, the block adds two outputs and two counters:
  - grantCount_o [31:0]: total grants.
  - conflictCount_o [31:0]: cycles with at least 2 valid requests and no cdbStall_i/flush_i.
  - Both counters reset to 0, increment by 1 per qualifying cycle, and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and counters are absent, and arbitration behaviour is identical.

Test Plan:
- Reset, then valid_i=3'b000 -> canGo_o=0. Next cycle cdbValid_o=0 and all data outputs 0.
- Unit 1 alone, valid_i=3'b010, tag=5'd7, val=64'd18 -> canGo_o=3'b010 every cycle. Next cycle cdbValid_o=1, cdbTag_o=7, cdbVal_o=18, cdbUnit_o=1.
- valid_i=3'b111 held for 6 cycles from reset -> grant sequence 001,010,100,001,010,100; cdbUnit_o sequence 0,1,2,0,1,2 lagging one cycle.
- valid_i=3'b101, rrPtr_r=1 -> grant unit 2, then unit 0 (wrap), then unit 2.
- valid_i=3'b011 with cdbStall_i=1 for 2 cycles -> canGo_o=0, cdbValid_o=0, rrPtr_r unchanged. After release, the grant goes to the unit at rrPtr_r.
- Grant to unit 0 in the same cycle flush_i=1 -> canGo_o=0, cdbValid_o=0 next cycle. With CDB_ARB_PERF_EN defined, conflictCount_o does not increment in that cycle.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that grants one execute stage per cycle and registers the winner onto the CDB.
// Optional grant/conflict performance counters are enabled with `define CDB_ARB_PERF_EN.
`timescale 1ns/1ps
module cdb_arbiter #(
  parameter int NUM_UNITS  = 3,
  parameter int ROBsize    = 16,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_UNITS-1:0]            valid_i,
  input  logic [NUM_UNITS*ROBsizeLog-1:0] tag_i,
  input  logic [NUM_UNITS*64-1:0]         val_i,
  input  logic [NUM_UNITS*4-1:0]          flags_i,
  input  logic                            cdbStall_i,
  input  logic                            flush_i,
  output logic [NUM_UNITS-1:0]            canGo_o,
  output logic                            cdbValid_o,
  output logic [ROBsizeLog-1:0]           cdbTag_o,
  output logic [63:0]                     cdbVal_o,
  output logic [3:0]                      cdbFlags_o,
`ifdef CDB_ARB_PERF_EN
  output logic [31:0]                     grantCount_o,
  output logic [31:0]                     conflictCount_o,
`endif
  output logic [$clog2(NUM_UNITS)-1:0]    cdbUnit_o
);

  localparam int UW = $clog2(NUM_UNITS);

  logic [UW-1:0]          r_rrPtr;
  logic                   r_vld_p1;
  logic [ROBsizeLog-1:0]  r_tag_p1;
  logic [63:0]            r_val_p1;
  logic [3:0]             r_flags_p1;
  logic [UW-1:0]          r_unit_p1;

  logic                   w_any_p0;
  logic [UW-1:0]          w_winner_p0;
  logic [NUM_UNITS-1:0]   w_grant_p0;
  logic [UW-1:0]          w_ptrNext;

  // Scan from the round-robin pointer with explicit wrap so non-power-of-2 sizes stay in range.
  always_comb begin
    logic [UW:0] v_sum;
    v_sum       = '0;
    w_any_p0    = 1'b0;
    w_winner_p0 = '0;
    w_grant_p0  = '0;
    if (!reset_i && !cdbStall_i && !flush_i) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        v_sum = {1'b0, r_rrPtr} + (UW+1)'(i);
        if (v_sum >= (UW+1)'(NUM_UNITS))
          v_sum = v_sum - (UW+1)'(NUM_UNITS);
        if (!w_any_p0 && valid_i[v_sum[UW-1:0]]) begin
          w_any_p0    = 1'b1;
          w_winner_p0 = v_sum[UW-1:0];
        end
      end
    end
    w_grant_p0[w_winner_p0] = w_any_p0;
  end

  assign w_ptrNext = (w_winner_p0 == UW'(NUM_UNITS - 1)) ? '0 : w_winner_p0 + 1'b1;
  assign canGo_o   = w_grant_p0;

  // p0 -> p1: register the granted unit's payload onto the CDB
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rrPtr    <= '0;
      r_vld_p1   <= 1'b0;
      r_tag_p1   <= '0;
      r_val_p1   <= '0;
      r_flags_p1 <= '0;
      r_unit_p1  <= '0;
    end else begin
      r_vld_p1 <= w_any_p0;
      if (w_any_p0) begin
        r_rrPtr    <= w_ptrNext;
        r_tag_p1   <= tag_i[w_winner_p0*ROBsizeLog +: ROBsizeLog];
        r_val_p1   <= val_i[w_winner_p0*64 +: 64];
        r_flags_p1 <= flags_i[w_winner_p0*4 +: 4];
        r_unit_p1  <= w_winner_p0;
      end
    end
  end

  assign cdbValid_o = r_vld_p1;
  assign cdbTag_o   = r_tag_p1;
  assign cdbVal_o   = r_val_p1;
  assign cdbFlags_o = r_flags_p1;
  assign cdbUnit_o  = r_unit_p1;

`ifdef CDB_ARB_PERF_EN
  logic [31:0] r_grantCnt;
  logic [31:0] r_conflictCnt;
  logic        w_conflict;

  assign w_conflict = !reset_i && !cdbStall_i && !flush_i && ($countones(valid_i) >= 2);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_grantCnt    <= '0;
      r_conflictCnt <= '0;
    end else begin
      if (w_any_p0 && (r_grantCnt != 32'hFFFF_FFFF))
        r_grantCnt <= r_grantCnt + 32'd1;
      if (w_conflict && (r_conflictCnt != 32'hFFFF_FFFF))
        r_conflictCnt <= r_conflictCnt + 32'd1;
    end
  end

  assign grantCount_o    = r_grantCnt;
  assign conflictCount_o = r_conflictCnt;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with three units; counters checked when CDB_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int TW = 5;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [N-1:0]      valid_i;
  logic [N*TW-1:0]   tag_i;
  logic [N*64-1:0]   val_i;
  logic [N*4-1:0]    flags_i;
  logic              cdbStall_i;
  logic              flush_i;
  logic [N-1:0]      canGo_o;
  logic              cdbValid_o;
  logic [TW-1:0]     cdbTag_o;
  logic [63:0]       cdbVal_o;
  logic [3:0]        cdbFlags_o;
  logic [1:0]        cdbUnit_o;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]       grantCount_o;
  logic [31:0]       conflictCount_o;
`endif

  int errors = 0;
  int checks = 0;

  logic [TW-1:0] tags  [N];
  logic [63:0]   vals  [N];
  logic [3:0]    flgs  [N];

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_UNITS(N), .ROBsize(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .tag_i(tag_i),
    .val_i(val_i), .flags_i(flags_i), .cdbStall_i(cdbStall_i), .flush_i(flush_i),
    .canGo_o(canGo_o), .cdbValid_o(cdbValid_o), .cdbTag_o(cdbTag_o),
    .cdbVal_o(cdbVal_o), .cdbFlags_o(cdbFlags_o),
`ifdef CDB_ARB_PERF_EN
    .grantCount_o(grantCount_o), .conflictCount_o(conflictCount_o),
`endif
    .cdbUnit_o(cdbUnit_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the combinational grant, clock it, then check the registered broadcast.
  task automatic step(input string tag, input logic [N-1:0] expGnt);
    int k;
    #1;
    check({tag, "_canGo"}, 64'(canGo_o), 64'(expGnt));
    tick();
    if (expGnt == '0) begin
      check({tag, "_cdbValid"}, 64'(cdbValid_o), 64'd0);
    end else begin
      k = (expGnt == 3'b001) ? 0 : (expGnt == 3'b010) ? 1 : 2;
      check({tag, "_cdbValid"}, 64'(cdbValid_o), 64'd1);
      check({tag, "_cdbUnit"},  64'(cdbUnit_o),  64'(k));
      check({tag, "_cdbTag"},   64'(cdbTag_o),   64'(tags[k]));
      check({tag, "_cdbVal"},   cdbVal_o,        vals[k]);
      check({tag, "_cdbFlags"}, 64'(cdbFlags_o), 64'(flgs[k]));
    end
  endtask

  initial begin
    tags[0] = 5'd1;  vals[0] = 64'd100;                 flgs[0] = 4'h1;
    tags[1] = 5'd7;  vals[1] = 64'd18;                  flgs[1] = 4'h2;
    tags[2] = 5'd12; vals[2] = 64'hDEAD_BEEF_0123_4567; flgs[2] = 4'h8;
    tag_i   = {tags[2], tags[1], tags[0]};
    val_i   = {vals[2], vals[1], vals[0]};
    flags_i = {flgs[2], flgs[1], flgs[0]};
    reset_i = 1'b1; valid_i = 3'b111; cdbStall_i = 1'b0; flush_i = 1'b0;

    // Reset: no grant even with requests pending
    #1;
    check("rst_canGo", 64'(canGo_o), 64'd0);
    tick(); tick();
    reset_i = 1'b0; valid_i = 3'b000;
    #1;
    check("idle_canGo", 64'(canGo_o), 64'd0);
    tick();
    check("idle_cdbValid", 64'(cdbValid_o), 64'd0);
    check("idle_tag",   64'(cdbTag_o),   64'd0);
    check("idle_val",   cdbVal_o,        64'd0);
    check("idle_flags", 64'(cdbFlags_o), 64'd0);
    check("idle_unit",  64'(cdbUnit_o),  64'd0);

    // All units requesting: strict rotation 0,1,2,0,1,2
    valid_i = 3'b111;
    for (int c = 0; c < 6; c++) step("rr", 3'(1 << (c % 3)));

    // Single requester granted back-to-back
    valid_i = 3'b010;
    for (int c = 0; c < 3; c++) step("single", 3'b010);

    // Pointer now 2; one grant to unit 0 moves it to 1
    valid_i = 3'b001;
    step("toPtr1", 3'b001);
    valid_i = 3'b101;
    step("wrap_a", 3'b100);
    step("wrap_b", 3'b001);
    step("wrap_c", 3'b100);

    // Stall with pointer 0: no grants, then unit 0 wins on release
    valid_i = 3'b011; cdbStall_i = 1'b1;
    step("stall1", 3'b000);
    step("stall2", 3'b000);
    cdbStall_i = 1'b0;
    step("stallRel", 3'b001);

    // Flush while unit 0 would win (pointer 1, only unit 0 requesting)
    valid_i = 3'b001; flush_i = 1'b1;
    step("flush", 3'b000);
    cdbStall_i = 1'b1;
    step("flushStall", 3'b000);
    cdbStall_i = 1'b0; flush_i = 1'b0; valid_i = 3'b011;
    step("postFlush", 3'b010);

    // Reset mid-operation abandons the pending grant
    valid_i = 3'b111;
    step("preRst", 3'b100);
    reset_i = 1'b1;
    step("midRst", 3'b000);
    check("midRst_tag",  64'(cdbTag_o),  64'd0);
    check("midRst_val",  cdbVal_o,       64'd0);
    check("midRst_unit", 64'(cdbUnit_o), 64'd0);
    reset_i = 1'b0;
`ifdef CDB_ARB_PERF_EN
    check("perf_rst_grant",    64'(grantCount_o),    64'd0);
    check("perf_rst_conflict", 64'(conflictCount_o), 64'd0);
`endif
    step("afterRst_a", 3'b001);
    step("afterRst_b", 3'b010);
    step("afterRst_c", 3'b100);
    valid_i = 3'b011; flush_i = 1'b1;
    step("perfFlush", 3'b000);
    flush_i = 1'b0; valid_i = 3'b001;
    step("perfSingle", 3'b001);
`ifdef CDB_ARB_PERF_EN
    check("perf_grant",    64'(grantCount_o),    64'd4);
    check("perf_conflict", 64'(conflictCount_o), 64'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
